// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and multiply-sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_NOT = 4'b0111;
    localparam logic [3:0] ALU_LSR = 4'b1000;
    localparam logic [3:0] ALU_LSL = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier that borrows the shared ALU; CPU requests pass through when idle.
// Optional MUL_EARLY_EXIT_EN: a zero operand skips the iterations and finishes in one cycle.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   mul_a,
    input  logic [WIDTH-1:0]   mul_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               cpu_stall,
    input  logic [WIDTH-1:0]   cpu_A,
    input  logic [WIDTH-1:0]   cpu_B,
    input  logic               cpu_cin,
    input  logic [3:0]         cpu_ALUop,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    output logic               Ext_cin,
    output logic [3:0]         ALUop,
    input  logic [WIDTH-1:0]   y,
    input  logic               c,
    output seq_state_t         dbg_state
);

    seq_state_t       state;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   sum;

`ifdef MUL_EARLY_EXIT_EN
    logic zero_ops;
    assign zero_ops = (mul_a == '0) || (mul_b == '0);
`endif

    assign busy      = (state == S_ITER);
    assign cpu_stall = busy;
    assign dbg_state = state;

    // Owner mux: the sequencer only takes the ALU while iterating, DONE included in pass-through.
    assign A       = busy ? p_hi : cpu_A;
    assign B       = busy ? m : cpu_B;
    assign Ext_cin = busy ? 1'b0 : cpu_cin;
    assign ALUop   = busy ? ALU_ADD : cpu_ALUop;

    // Partial sum including ALU carry; the add result is only kept when the multiplier bit is set.
    always_comb begin
        sum = {1'b0, p_hi};
        if (p_lo[0]) begin
            sum = {c, y};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            done    <= 1'b0;
            product <= '0;
            m       <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        m    <= mul_a;
                        p_hi <= '0;
                        p_lo <= mul_b;
                        cnt  <= '0;
`ifdef MUL_EARLY_EXIT_EN
                        if (zero_ops) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            product <= '0;
                        end else begin
                            state <= S_ITER;
                        end
`else
                        state <= S_ITER;
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ITER: begin
                    {p_hi, p_lo} <= {sum, p_lo[WIDTH-1:1]};
                    cnt          <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        product <= {sum, p_lo[WIDTH-1:1]};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural ALU beside the DUT, queue scoreboard checked on done.
module tb_alu_mul_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  mul_a, mul_b;
    logic        busy, done, cpu_stall;
    logic [15:0] product;
    logic [7:0]  cpu_A, cpu_B;
    logic        cpu_cin;
    logic [3:0]  cpu_ALUop;
    logic [7:0]  A, B;
    logic        Ext_cin;
    logic [3:0]  ALUop;
    logic [7:0]  y;
    logic        c;
    seq_state_t  dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [15:0] exp_q[$];
    int          lat_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_mul_seq #(.WIDTH(8), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mul_a(mul_a), .mul_b(mul_b),
        .busy(busy), .done(done), .product(product), .cpu_stall(cpu_stall),
        .cpu_A(cpu_A), .cpu_B(cpu_B), .cpu_cin(cpu_cin), .cpu_ALUop(cpu_ALUop),
        .A(A), .B(B), .Ext_cin(Ext_cin), .ALUop(ALUop), .y(y), .c(c),
        .dbg_state(dbg_state)
    );

    // Behavioural model of the shared 8-bit ALU.
    always_comb begin
        {c, y} = 9'd0;
        case (ALUop)
            ALU_ADD: {c, y} = {1'b0, A} + {1'b0, B} + {8'd0, Ext_cin};
            ALU_SUB: {c, y} = {1'b0, A} - {1'b0, B};
            ALU_AND: y = A & B;
            ALU_OR:  y = A | B;
            ALU_XOR: y = A ^ B;
            ALU_NOT: y = ~A;
            ALU_LSR: {y, c} = {1'b0, A};
            ALU_LSL: {c, y} = {A, 1'b0};
            default: {c, y} = 9'd0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef MUL_EARLY_EXIT_EN
        return (a == 8'd0 || b == 8'd0) ? 1 : 9;
`else
        return 9;
`endif
    endfunction

    // Called at a negedge; returns at the negedge of the first cycle after the accept edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit hold);
        mul_a = a;
        mul_b = b;
        start = 1'b1;
        exp_q.push_back(16'(a) * 16'(b));
        lat_q.push_back(cyc + exp_lat(a, b));
        @(negedge clk);
        if (!hold) start = 1'b0;
        if (exp_lat(a, b) == 9) begin
            check("busy_iter", busy, 1);
            check("stall_iter", cpu_stall, 1);
            check("state_iter", dbg_state, S_ITER);
            check("aluop_owned", ALUop, ALU_ADD);
            check("cin_owned", Ext_cin, 0);
            check("b_is_m", B, a);
        end else begin
            check("busy_early", busy, 0);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL timeout: %0d results outstanding expected 0", exp_q.size());
            exp_q.delete();
            lat_q.delete();
        end
    endtask

    // Monitor: every done pulse pops the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL spurious_done: got done=1 expected 0 (cycle %0d)", cyc);
            end else begin
                logic [15:0] ep;
                int el;
                ep = exp_q.pop_front();
                el = lat_q.pop_front();
                check("product", product, ep);
                check("done_cycle", cyc, el);
                check("done_passthru", A, cpu_A);
                check("done_busy", busy, 0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mul_a = 8'd0;
        mul_b = 8'd0;
        cpu_A = 8'd5;
        cpu_B = 8'd10;
        cpu_cin = 1'b0;
        cpu_ALUop = ALU_ADD;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        check("rst_state", dbg_state, S_IDLE);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle pass-through
        check("pass_y", y, 15);
        check("pass_stall", cpu_stall, 0);
        check("pass_A", A, 5);
        cpu_cin = 1'b1;
        #1;
        check("pass_cin_y", y, 16);
        cpu_ALUop = ALU_XOR;
        #1;
        check("pass_xor_y", y, 8'h0F);
        @(negedge clk);

        // 5x10 with a start pulse mid-ITER that must be ignored
        issue(8'd5, 8'd10, 0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        mul_a = 8'd1;
        mul_b = 8'd1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        check("product_hold", product, 16'd50);

        // Back-to-back: start held through DONE, operands changed while busy
        issue(8'd3, 8'd7, 1);
        repeat (2) @(negedge clk);
        mul_a = 8'hAA;
        mul_b = 8'h55;
        repeat (6) @(negedge clk);
        issue(8'd12, 8'd12, 0);
        check("b2b_hold_prev", product, 16'd21);
        wait_idle();
        @(negedge clk);

        // Zero operand
        issue(8'd0, 8'd200, 0);
        wait_idle();
        @(negedge clk);

        // Carry captured every iteration
        issue(8'hFF, 8'hFF, 0);
        wait_idle();
        @(negedge clk);

        // Reset in ITER cycle 4 aborts with no done
        issue(8'd9, 8'd9, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_product", product, 0);
        check("abort_state", dbg_state, S_IDLE);
        check("abort_done", done, 0);
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_abort_idle", dbg_state, S_IDLE);
        issue(8'd9, 8'd9, 0);
        wait_idle();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
